// File: rtl/mem_arbiter.sv
//============================================================================
// mem_arbiter
//   Two-port arbiter onto a single data-memory port (IDLE/ACCESS/DONE).
//   Revision: 1.0
//============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] adr0,
   input  logic [31:0] adr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic [31:0] mem_adr,
   output logic [31:0] to_be_written_data,
   output logic        MemWrite,
   input  logic [31:0] read_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        gsel;
   logic        grant_nx;
   logic        last;
   logic        lat_we;
   logic [31:0] lat_adr;
   logic [31:0] lat_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = gsel;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               // last resets to 1, so the first tie goes to port 0 in both modes
               grant_nx = (FIXED_PRIO != 0) ? 1'b0 : ~last;
               state_nx = ACCESS;
            end else if (req0) begin
               grant_nx = 1'b0;
               state_nx = ACCESS;
            end else if (req1) begin
               grant_nx = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gsel      <= 1'b0;
         last      <= 1'b1;
         lat_we    <= 1'b0;
         lat_adr   <= 32'd0;
         lat_wdata <= 32'd0;
         rdata0    <= 32'd0;
         rdata1    <= 32'd0;
      end else begin
         if (state == IDLE && state_nx == ACCESS) begin
            gsel      <= grant_nx;
            lat_we    <= grant_nx ? we1    : we0;
            lat_adr   <= grant_nx ? adr1   : adr0;
            lat_wdata <= grant_nx ? wdata1 : wdata0;
         end
         if (state == ACCESS && !lat_we) begin
            if (gsel) begin
               rdata1 <= read_data;
            end else begin
               rdata0 <= read_data;
            end
         end
         if (state == DONE) begin
            last <= gsel;
         end
      end
   end

   // Decoded from the state register so an asynchronous reset kills the write at once
   assign MemWrite           = (state == ACCESS) && lat_we;
   assign mem_adr            = lat_adr;
   assign to_be_written_data = lat_wdata;
   assign ack0               = (state == DONE) && !gsel;
   assign ack1               = (state == DONE) && gsel;
   assign busy               = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//============================================================================
// tb_mem_arbiter
//   Self-checking bench: round-robin and fixed-priority instances on models.
//   Revision: 1.0
//============================================================================
`default_nettype none

module tb_mem_arbiter;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] adr;
      logic [31:0] wdata;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] adr0 = 32'd0, adr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;

   logic        ack0, ack1, mw, busy;
   logic [31:0] rdata0, rdata1, mem_adr, wd, rd;
   logic        ack0_f, ack1_f, mw_f, busy_f;
   logic [31:0] rdata0_f, rdata1_f, mem_adr_f, wd_f, rd_f;

   logic [31:0] mem   [256];
   logic [31:0] mem_f [256];

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mw_cnt = 0;
   int          fp_a0 = 0;
   int          fp_a1 = 0;
   exp_t        sb[$];
   logic [31:0] exp_rd [2];
   vec_t        vecs [9];

   always #5 clk = ~clk;

   mem_arbiter #(.FIXED_PRIO(0)) dut_rr (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_adr(mem_adr), .to_be_written_data(wd), .MemWrite(mw),
      .read_data(rd), .busy(busy)
   );

   mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0_f), .ack1(ack1_f), .rdata0(rdata0_f), .rdata1(rdata1_f),
      .mem_adr(mem_adr_f), .to_be_written_data(wd_f), .MemWrite(mw_f),
      .read_data(rd_f), .busy(busy_f)
   );

   // Word-addressed memories; address bits [1:0] are ignored
   assign rd   = mem[mem_adr[9:2]];
   assign rd_f = mem_f[mem_adr_f[9:2]];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = 32'h0;
         mem_f[i] = 32'h0;
      end
      mem[250]   = 32'h11223344;
      mem_f[250] = 32'h11223344;
      mem[252]   = 32'h55AA55AA;
      mem_f[252] = 32'h55AA55AA;
      forever begin
         @(posedge clk);
         if (mw)   mem[mem_adr[9:2]]     = wd;
         if (mw_f) mem_f[mem_adr_f[9:2]] = wd_f;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every round-robin ack consumes one expected {port, rdata}
   always @(negedge clk) begin
      if (mw)     mw_cnt++;
      if (ack0_f) fp_a0++;
      if (ack1_f) fp_a1++;
      if (ack0 && ack1) check("ack_both", 32'd1, 32'd0);
      if (ack0 || ack1) begin
         if (sb.size() == 0) begin
            check("ack_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_port", 32'(ack1), 32'(e.port));
            check("sb_rdata", ack1 ? rdata1 : rdata0, e.rdata);
         end
      end
   end

   task automatic set_port(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      if (p) begin
         req1 = r; we1 = w; adr1 = a; wdata1 = d;
      end else begin
         req0 = r; we0 = w; adr0 = a; wdata0 = d;
      end
   endtask

   task automatic wait_ack(output int k, output bit got, output bit p);
      got = 1'b0;
      p   = 1'b0;
      k   = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (ack0 || ack1) begin
            got = 1'b1;
            p   = ack1;
            k   = i;
            break;
         end
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_access(input vec_t v);
      int k;
      bit got, p;
      @(posedge clk);
      #1;
      mw_cnt = 0;
      set_port(v.port, 1'b1, v.we, v.adr, v.wdata);
      if (!v.we) exp_rd[v.port] = v.rd;
      sb.push_back('{v.port, exp_rd[v.port]});
      wait_ack(k, got, p);
      check("ack_latency", k, 32'd2);
      check("ack_port", 32'(p), 32'(v.port));
      check("memwrite_cycles", mw_cnt, 32'(v.we));
      set_port(v.port, 1'b0, 1'b0, v.adr, v.wdata);
   endtask

   initial begin
      int  k, prev;
      bit  got, p;

      vecs[0] = '{1'b0, 1'b0, 32'h3E8, 32'h0,        32'h11223344};
      vecs[1] = '{1'b1, 1'b1, 32'h3EC, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h3EC, 32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b0, 32'h3E8, 32'h0,        32'h11223344};
      vecs[4] = '{1'b0, 1'b1, 32'h3E8, 32'hCAFEF00D, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h3E8, 32'h0,        32'hCAFEF00D};
      vecs[6] = '{1'b0, 1'b1, 32'h000, 32'h12345678, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 32'h003, 32'h0,        32'h12345678};
      vecs[8] = '{1'b1, 1'b0, 32'h3EC, 32'h0,        32'hDEADBEEF};
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack0", 32'(ack0), 32'd0);
      check("rst_ack1", 32'(ack1), 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      check("rst_memwrite", 32'(mw), 32'd0);
      check("rst_mem_adr", mem_adr, 32'd0);
      check("rst_wdata", wd, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) do_access(vecs[i]);

      // Address changed after the grant must not reach the memory
      @(posedge clk);
      #1;
      set_port(1'b0, 1'b1, 1'b0, 32'h3E8, 32'h0);
      exp_rd[0] = 32'hCAFEF00D;
      sb.push_back('{1'b0, exp_rd[0]});
      @(posedge clk);
      #1;
      check("chg_busy", 32'(busy), 32'd1);
      check("chg_mem_adr_access", mem_adr, 32'h3E8);
      adr0 = 32'h3EC;
      wait_ack(k, got, p);
      check("chg_latency", k, 32'd1);
      check("chg_mem_adr_done", mem_adr, 32'h3E8);
      req0 = 1'b0;

      // Reset during the ACCESS cycle of a write
      @(posedge clk);
      #1;
      set_port(1'b1, 1'b1, 1'b1, 32'h3F0, 32'hBAD0BAD0);
      @(posedge clk);
      #1;
      check("abort_memwrite_before", 32'(mw), 32'd1);
      rst = 1'b0;
      #1;
      check("abort_memwrite", 32'(mw), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ack1", 32'(ack1), 32'd0);
      set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_mem", mem[252], 32'h55AA55AA);
      check("abort_mem_f", mem_f[252], 32'h55AA55AA);
      check("abort_rdata1", rdata1, 32'd0);
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;

      // Contention held from reset: round-robin alternates, fixed priority keeps port 0
      @(negedge clk);
      rst = 1'b0;
      set_port(1'b0, 1'b1, 1'b0, 32'h3E8, 32'h0);
      set_port(1'b1, 1'b1, 1'b0, 32'h3EC, 32'h0);
      sb.push_back('{1'b0, 32'hCAFEF00D});
      sb.push_back('{1'b1, 32'hDEADBEEF});
      sb.push_back('{1'b0, 32'hCAFEF00D});
      sb.push_back('{1'b1, 32'hDEADBEEF});
      fp_a0 = 0;
      fp_a1 = 0;
      @(negedge clk);
      rst  = 1'b1;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ack(k, got, p);
         check("rr_port", 32'(p), 32'(i % 2));
         if (i > 0) check("rr_spacing", cyc - prev, 32'd3);
         prev = cyc;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("fp_ack0_count", fp_a0, 32'd4);
      check("fp_ack1_count", fp_a1, 32'd0);
      check("fp_rdata0", rdata0_f, 32'hCAFEF00D);
      check("sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
